multi_clock_divider: RTL and testbench

Parametrised multi-channel clock divider and tick generator for display scan, debounce and PWM timebases. Each of NUM_CH channels divides clk_in by a runtime-programmable integer, driving either a near-50% square output or a one-cycle strobe. Divisor changes are glitch-free, taking effect at the channel's period boundary. A global sync realigns all channels.

---
 rtl/multi_clock_divider_if.sv | 25 ++
 rtl/multi_clock_divider.sv | 113 +++++++++++
 tb/tb_multi_clock_divider.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_clock_divider_if.sv
// Control and status bundle for multi_clock_divider: per-channel enables,
// modes, divisor load port, global sync, and the divided outputs.
interface multi_clock_divider_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
);
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       mode;
    logic [NUM_CH*CNT_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_load;
    logic                    sync_clr;
    logic [NUM_CH-1:0]       div_busy;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       clk_out;

    modport master (
        output en, mode, div_in, div_load, sync_clr,
        input  div_busy, tick, clk_out
    );

    modport slave (
        input  en, mode, div_in, div_load, sync_clr,
        output div_busy, tick, clk_out
    );
endinterface

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers / tick generators with
// glitch-free divisor reload at the period boundary and a global realign.
module multi_clock_divider #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 25000
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    multi_clock_divider_if.slave   bus
);
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t clamp_div(input cnt_t v);
        return (v < cnt_t'(2)) ? cnt_t'(2) : v;
    endfunction

    localparam cnt_t DEF_DIV = (DEFAULT_DIV < 2) ? cnt_t'(2) : cnt_t'(DEFAULT_DIV);

    logic [NUM_CH-1:0] busy_v;
    logic [NUM_CH-1:0] tick_v;
    logic [NUM_CH-1:0] clk_v;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cnt_t cnt_q, cnt_d;
        cnt_t div_act_q, div_act_d;
        cnt_t div_pend_q, div_pend_d;
        logic busy_q, busy_d;
        logic tick_q, tick_d;
        logic clk_q, clk_d;

        cnt_t load_val;
        cnt_t cnt_nxt;
        logic wrap;

        assign load_val = clamp_div(bus.div_in[g*CNT_W +: CNT_W]);
        assign wrap     = (cnt_q == div_act_q - cnt_t'(1));
        assign cnt_nxt  = wrap ? '0 : cnt_q + cnt_t'(1);

        always_comb begin
            cnt_d      = cnt_q;
            div_act_d  = div_act_q;
            div_pend_d = div_pend_q;
            busy_d     = busy_q;
            tick_d     = 1'b0;
            clk_d      = clk_q;
            if (bus.sync_clr) begin
                cnt_d  = '0;
                clk_d  = 1'b0;
                busy_d = 1'b0;
                if (bus.div_load[g]) begin
                    div_act_d  = load_val;
                    div_pend_d = load_val;
                end else if (busy_q) begin
                    div_act_d = div_pend_q;
                end
            end else if (!bus.en[g]) begin
                // Idle channel takes a new divisor immediately and restarts its period.
                if (bus.div_load[g]) begin
                    div_act_d  = load_val;
                    div_pend_d = load_val;
                    cnt_d      = '0;
                    clk_d      = 1'b0;
                    busy_d     = 1'b0;
                end
            end else begin
                cnt_d  = cnt_nxt;
                tick_d = wrap;
                if (wrap) begin
                    busy_d = 1'b0;
                    if (bus.div_load[g]) begin
                        div_act_d  = load_val;
                        div_pend_d = load_val;
                    end else if (busy_q) begin
                        div_act_d = div_pend_q;
                    end
                end else if (bus.div_load[g]) begin
                    div_pend_d = load_val;
                    busy_d     = 1'b1;
                end
                // On wrap cnt_nxt is 0, so the square output always falls with tick.
                clk_d = bus.mode[g] ? wrap
                                    : (cnt_nxt >= div_act_q - (div_act_q >> 1));
            end
        end

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q      <= '0;
                div_act_q  <= DEF_DIV;
                div_pend_q <= DEF_DIV;
                busy_q     <= 1'b0;
                tick_q     <= 1'b0;
                clk_q      <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                div_act_q  <= div_act_d;
                div_pend_q <= div_pend_d;
                busy_q     <= busy_d;
                tick_q     <= tick_d;
                clk_q      <= clk_d;
            end
        end

        assign busy_v[g] = busy_q;
        assign tick_v[g] = tick_q;
        assign clk_v[g]  = clk_q;
    end

    assign bus.div_busy = busy_v;
    assign bus.tick     = tick_v;
    assign bus.clk_out  = clk_v;
endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: 4 channels, DEFAULT_DIV 10, edges
// counted from reset release; expected values are hand-derived per edge.
module tb_multi_clock_divider;
    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 16;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    int   edge_cnt = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    multi_clock_divider_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    multi_clock_divider #(
        .NUM_CH(NCH),
        .CNT_W(CW),
        .DEFAULT_DIV(10)
    ) dut (
        .clk_in(clk_in),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         n;
        logic [3:0] tick;
        logic [3:0] clk;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk_in);
        #1;
        edge_cnt++;
    endtask

    task automatic run_to(input int n);
        while (edge_cnt < n) step();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, got, exp);
        end
    endtask

    task automatic set_div(input int ch, input logic [CW-1:0] val);
        bus.div_in[ch*CW +: CW] = val;
    endtask

    task automatic load_now(input logic [3:0] mask);
        bus.div_load = mask;
        step();
        bus.div_load = '0;
    endtask

    initial begin
        bus.en       = 4'hF;
        bus.mode     = 4'b1000;
        bus.div_in   = '0;
        bus.div_load = '0;
        bus.sync_clr = 1'b0;

        vecs[0] = '{n:  4, tick: 4'b0000, clk: 4'b0000};
        vecs[1] = '{n:  5, tick: 4'b0000, clk: 4'b0111};
        vecs[2] = '{n:  9, tick: 4'b0000, clk: 4'b0111};
        vecs[3] = '{n: 10, tick: 4'b1111, clk: 4'b1000};
        vecs[4] = '{n: 11, tick: 4'b0000, clk: 4'b0000};
        vecs[5] = '{n: 15, tick: 4'b0000, clk: 4'b0111};
        vecs[6] = '{n: 20, tick: 4'b1111, clk: 4'b1000};
        vecs[7] = '{n: 25, tick: 4'b0000, clk: 4'b0111};
        vecs[8] = '{n: 30, tick: 4'b1111, clk: 4'b1000};

        repeat (2) @(posedge clk_in);
        #1;
        check("rst_tick", bus.tick, 4'b0000);
        check("rst_clk", bus.clk_out, 4'b0000);
        check("rst_busy", bus.div_busy, 4'b0000);
        @(negedge clk_in);
        rst_n = 1'b1;
        edge_cnt = 0;

        // Default divisor 10, ch0..2 square, ch3 pulse
        for (int i = 0; i < 9; i++) begin
            run_to(vecs[i].n);
            check("tbl_tick", bus.tick, vecs[i].tick);
            check("tbl_clk", bus.clk_out, vecs[i].clk);
            check("tbl_busy", bus.div_busy, 4'b0000);
        end

        // Load 7 on ch0 at period cycle 3, applied at the wrap on edge 40
        run_to(32);
        set_div(0, 16'd7);
        load_now(4'b0001);
        check("ld7_busy33", bus.div_busy, 4'b0001);
        run_to(39);
        check("ld7_busy39", bus.div_busy, 4'b0001);
        check("ld7_tick39", bus.tick, 4'b0000);
        run_to(40);
        check("ld7_busy40", bus.div_busy, 4'b0000);
        check("ld7_tick40", bus.tick, 4'b1111);
        check("ld7_clk40", bus.clk_out[0], 1'b0);
        run_to(43);
        check("ld7_clk43", bus.clk_out[0], 1'b0);
        run_to(44);
        check("ld7_clk44", bus.clk_out[0], 1'b1);
        run_to(46);
        check("ld7_clk46", bus.clk_out[0], 1'b1);
        run_to(47);
        check("ld7_tick47", bus.tick, 4'b0001);
        check("ld7_clk47", bus.clk_out[0], 1'b0);
        run_to(50);
        check("ld7_tick50", bus.tick, 4'b1110);
        run_to(54);
        check("ld7_tick54", bus.tick, 4'b0001);

        // Divisors 0 and 1 on ch1/ch2 clamp to 2
        run_to(54);
        set_div(1, 16'd0);
        set_div(2, 16'd1);
        load_now(4'b0110);
        check("clamp_busy55", bus.div_busy, 4'b0110);
        run_to(60);
        check("clamp_busy60", bus.div_busy, 4'b0000);
        check("clamp_tick60", bus.tick, 4'b1110);
        run_to(61);
        check("clamp_tick61", bus.tick, 4'b0001);
        check("clamp_clk61", bus.clk_out[2:1], 2'b11);
        run_to(62);
        check("clamp_tick62", bus.tick, 4'b0110);
        check("clamp_clk62", bus.clk_out[2:1], 2'b00);
        run_to(63);
        check("clamp_tick63", bus.tick, 4'b0000);
        check("clamp_clk63", bus.clk_out[2:1], 2'b11);
        run_to(64);
        check("clamp_tick64", bus.tick, 4'b0110);

        // ch0 disabled for edges 73..76 while clk_out high
        run_to(72);
        check("en_clk72", bus.clk_out[0], 1'b1);
        bus.en[0] = 1'b0;
        run_to(75);
        check("en_tick75", bus.tick[0], 1'b0);
        check("en_clk75", bus.clk_out[0], 1'b1);
        run_to(76);
        check("en_clk76", bus.clk_out[0], 1'b1);
        bus.en[0] = 1'b1;
        run_to(78);
        check("en_tick78", bus.tick[0], 1'b0);
        run_to(79);
        check("en_tick79", bus.tick[0], 1'b1);
        check("en_clk79", bus.clk_out[0], 1'b0);
        run_to(85);
        check("en_tick85", bus.tick[0], 1'b0);
        run_to(86);
        check("en_tick86", bus.tick[0], 1'b1);

        // ch1 -> 4, ch2 -> 6, then sync_clr mid-count
        set_div(1, 16'd4);
        set_div(2, 16'd6);
        load_now(4'b0110);
        check("sy_busy87", bus.div_busy, 4'b0110);
        run_to(88);
        check("sy_busy88", bus.div_busy, 4'b0000);
        run_to(100);
        check("sy_tick100", bus.tick, 4'b1111);
        set_div(3, 16'd10);
        load_now(4'b1000);
        check("sy_busy101", bus.div_busy, 4'b1000);
        run_to(103);
        check("sy_clk103", bus.clk_out, 4'b0110);
        bus.sync_clr = 1'b1;
        step();
        bus.sync_clr = 1'b0;
        check("sy_tick104", bus.tick, 4'b0000);
        check("sy_clk104", bus.clk_out, 4'b0000);
        check("sy_busy104", bus.div_busy, 4'b0000);
        run_to(107);
        check("sy_tick107", bus.tick, 4'b0000);
        run_to(108);
        check("sy_tick108", bus.tick, 4'b0010);
        run_to(110);
        check("sy_tick110", bus.tick, 4'b0100);
        run_to(111);
        check("sy_tick111", bus.tick, 4'b0001);
        run_to(112);
        check("sy_tick112", bus.tick, 4'b0010);
        run_to(114);
        check("sy_tick114", bus.tick, 4'b1000);

        // Async reset mid-period with a pending load on ch0
        run_to(115);
        set_div(0, 16'd3);
        load_now(4'b0001);
        check("ar_busy_pre", bus.div_busy, 4'b0001);
        check("ar_clk_pre", bus.clk_out[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_tick", bus.tick, 4'b0000);
        check("ar_clk", bus.clk_out, 4'b0000);
        check("ar_busy", bus.div_busy, 4'b0000);
        @(negedge clk_in);
        rst_n = 1'b1;
        edge_cnt = 0;
        run_to(5);
        check("ar_clk5", bus.clk_out, 4'b0111);
        run_to(9);
        check("ar_tick9", bus.tick, 4'b0000);

        // Load landing exactly on the wrap edge bypasses the pending stage
        set_div(0, 16'd4);
        load_now(4'b0001);
        check("byp_tick10", bus.tick, 4'b1111);
        check("byp_busy10", bus.div_busy, 4'b0000);
        run_to(13);
        check("byp_tick13", bus.tick[0], 1'b0);
        run_to(14);
        check("byp_tick14", bus.tick[0], 1'b1);
        run_to(18);
        check("byp_tick18", bus.tick[0], 1'b1);
        check("dis_clk18", bus.clk_out[1], 1'b1);

        // Load while disabled: immediate, restarts the period
        bus.en[1] = 1'b0;
        set_div(1, 16'd3);
        load_now(4'b0010);
        check("dis_clk19", bus.clk_out[1], 1'b0);
        check("dis_busy19", bus.div_busy[1], 1'b0);
        check("dis_tick19", bus.tick[1], 1'b0);
        bus.en[1] = 1'b1;
        run_to(20);
        check("dis_tick20", bus.tick[1], 1'b0);
        run_to(21);
        check("dis_tick21", bus.tick[1], 1'b0);
        run_to(22);
        check("dis_tick22", bus.tick[1], 1'b1);
        run_to(25);
        check("dis_tick25", bus.tick[1], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
